// File: rtl/prf_free_list_pkg.sv
// Shared rename-stage sizing constants and the physical register number type.
package prf_free_list_pkg;

  localparam int NUM_P_REGS    = 48;
  localparam int NUM_A_REGS    = 32;
  localparam int MAX_FREE_REGS = NUM_P_REGS - NUM_A_REGS;
  localparam int RENAME_W      = 2;
  localparam int RETIRE_W      = 2;
  localparam int FL_CNT_W      = $clog2(MAX_FREE_REGS + 1);
  localparam int PRN_W         = $clog2(NUM_P_REGS);

  typedef logic [PRN_W-1:0] prn_t;

endpackage

// File: rtl/lane_prefix_count.sv
// Exclusive prefix popcount of a lane mask: o_prefix[i] = number of set lanes below i.
module lane_prefix_count #(
  parameter int N = 2
) (
  input  logic [N-1:0]                    i_mask,
  output logic [N-1:0][$clog2(N+1)-1:0]   o_prefix,
  output logic [$clog2(N+1)-1:0]          o_total
);

  localparam int CW = $clog2(N + 1);

  // Ripple accumulation in lane order.
  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    o_prefix = '0;
    for (int i = 0; i < N; i++) begin
      o_prefix[i] = acc;
      acc = acc + CW'(i_mask[i]);
    end
    o_total = acc;
  end

endmodule

// File: rtl/prf_free_list.sv
// Physical register free list: multi-lane allocate at the speculative head,
// multi-lane free at the tail, and a committed head that a flush snaps back to.
module prf_free_list
  import prf_free_list_pkg::*;
#(
  parameter int NUM_P_REGS = prf_free_list_pkg::NUM_P_REGS,
  parameter int NUM_A_REGS = prf_free_list_pkg::NUM_A_REGS,
  parameter int ALLOC_W    = prf_free_list_pkg::RENAME_W,
  parameter int FREE_W     = prf_free_list_pkg::RETIRE_W,
  localparam int DEPTH     = NUM_P_REGS - NUM_A_REGS,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int CA_W      = $clog2(ALLOC_W + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [ALLOC_W-1:0]         i_alloc_req,
  output logic                       o_alloc_ok,
  output prn_t [ALLOC_W-1:0]         o_alloc_prn,
  input  logic [FREE_W-1:0]          i_free_valid,
  input  prn_t [FREE_W-1:0]          i_free_prn,
  input  logic [CA_W-1:0]            i_commit_alloc_cnt,
  input  logic                       i_flush,
  output logic [CNT_W-1:0]           o_free_count,
  output logic                       o_empty,
  output logic                       o_overflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FC_W  = $clog2(FREE_W + 1);

  if (DEPTH < ALLOC_W) begin : g_depth_chk
    $error("prf_free_list: DEPTH must be at least ALLOC_W");
  end

  // Pointer advance with explicit wrap; DEPTH need not be a power of two, inc <= DEPTH.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [CNT_W-1:0] inc);
    logic [CNT_W:0] s;
    s = (CNT_W+1)'(p) + (CNT_W+1)'(inc);
    if (s >= (CNT_W+1)'(DEPTH)) s = s - (CNT_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  prn_t             r_fl [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_commit_head;
  logic [PTR_W-1:0] r_tail;
  // r_free_count covers [head, tail); r_commit_count covers [commit_head, tail).
  logic [CNT_W-1:0] r_free_count;
  logic [CNT_W-1:0] r_commit_count;
  logic             r_overflow_err;

  logic [ALLOC_W-1:0][CA_W-1:0] w_alloc_pre;
  logic [CA_W-1:0]              w_alloc_total;
  logic [FREE_W-1:0][FC_W-1:0]  w_free_pre;
  logic [FC_W-1:0]              w_free_total;

  logic             w_pop;
  logic [CNT_W-1:0] w_popped;
  logic [CNT_W-1:0] w_outstanding;
  logic [CNT_W-1:0] w_commit_req;
  logic             w_underflow;
  logic [CNT_W-1:0] w_commit;
  logic [CNT_W-1:0] w_room;
  logic [CNT_W-1:0] w_freed_req;
  logic             w_overflow;
  logic [CNT_W-1:0] w_freed;
  logic [PTR_W-1:0] w_commit_head_next;
  logic [PTR_W-1:0] w_head_next;
  logic [PTR_W-1:0] w_tail_next;
  logic [CNT_W-1:0] w_commit_count_next;
  logic [CNT_W-1:0] w_free_count_next;

  lane_prefix_count #(.N(ALLOC_W)) u_alloc_pfx (
    .i_mask   (i_alloc_req),
    .o_prefix (w_alloc_pre),
    .o_total  (w_alloc_total)
  );

  lane_prefix_count #(.N(FREE_W)) u_free_pfx (
    .i_mask   (i_free_valid),
    .o_prefix (w_free_pre),
    .o_total  (w_free_total)
  );

  assign o_alloc_ok     = r_free_count >= CNT_W'(w_alloc_total);
  assign o_free_count   = r_free_count;
  assign o_empty        = (r_free_count == '0);
  assign o_overflow_err = r_overflow_err;

  // Zero-cycle peek: each requesting lane sees the entry at head + its request rank.
  always_comb begin
    for (int i = 0; i < ALLOC_W; i++) begin
      o_alloc_prn[i] = r_fl[ptr_add(r_head, CNT_W'(w_alloc_pre[i]))];
    end
  end

  // Next-state pointers and counts; commits and frees are clamped so committed entries stay intact.
  always_comb begin
    w_pop         = o_alloc_ok && (|i_alloc_req) && !i_flush;
    w_popped      = w_pop ? CNT_W'(w_alloc_total) : '0;
    w_outstanding = r_commit_count - r_free_count;
    w_commit_req  = CNT_W'(i_commit_alloc_cnt);
    w_underflow   = w_commit_req > w_outstanding;
    w_commit      = w_underflow ? w_outstanding : w_commit_req;
    w_room        = CNT_W'(DEPTH) - r_commit_count;
    w_freed_req   = CNT_W'(w_free_total);
    w_overflow    = w_freed_req > w_room;
    w_freed       = w_overflow ? w_room : w_freed_req;

    w_commit_head_next  = ptr_add(r_commit_head, w_commit);
    w_head_next         = i_flush ? w_commit_head_next : ptr_add(r_head, w_popped);
    w_tail_next         = ptr_add(r_tail, w_freed);
    w_commit_count_next = r_commit_count - w_commit + w_freed;
    w_free_count_next   = i_flush ? w_commit_count_next
                                  : r_free_count - w_popped + w_freed;
  end

  // State update; reset wins over flush, alloc and free.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fl[i] <= prn_t'(NUM_A_REGS + i);
      end
      r_head         <= '0;
      r_commit_head  <= '0;
      r_tail         <= '0;
      r_free_count   <= CNT_W'(DEPTH);
      r_commit_count <= CNT_W'(DEPTH);
      r_overflow_err <= 1'b0;
    end else begin
      for (int j = 0; j < FREE_W; j++) begin
        if (i_free_valid[j] && (CNT_W'(w_free_pre[j]) < w_freed)) begin
          r_fl[ptr_add(r_tail, CNT_W'(w_free_pre[j]))] <= i_free_prn[j];
        end
      end
      r_head         <= w_head_next;
      r_commit_head  <= w_commit_head_next;
      r_tail         <= w_tail_next;
      r_free_count   <= w_free_count_next;
      r_commit_count <= w_commit_count_next;
      if (w_overflow || w_underflow) r_overflow_err <= 1'b1;
    end
  end

  a_count_bounds: assert property (@(posedge i_clk) disable iff (i_rst)
    (r_free_count <= r_commit_count) && (r_commit_count <= CNT_W'(DEPTH)));

endmodule

// File: tb/tb_prf_free_list.sv
// Self-checking bench for prf_free_list against a queue-based free list model.
module tb_prf_free_list;
  import prf_free_list_pkg::*;

  localparam int DEPTH = 16;

  logic                clk;
  logic                rst;
  logic [1:0]          req;
  logic                ok;
  prn_t [1:0]          prn;
  logic [1:0]          fv;
  prn_t [1:0]          fprn;
  logic [1:0]          commit;
  logic                flush;
  logic [FL_CNT_W-1:0] fc;
  logic                empty;
  logic                err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: fl_q holds committed-free registers in FIFO order; the first
  // 'spec' of them are speculatively allocated but not yet committed.
  int fl_q[$];
  int spec;
  bit m_err;

  prf_free_list dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_alloc_req        (req),
    .o_alloc_ok         (ok),
    .o_alloc_prn        (prn),
    .i_free_valid       (fv),
    .i_free_prn         (fprn),
    .i_commit_alloc_cnt (commit),
    .i_flush            (flush),
    .o_free_count       (fc),
    .o_empty            (empty),
    .o_overflow_err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void m_reset();
    fl_q.delete();
    for (int i = 0; i < DEPTH; i++) fl_q.push_back(32 + i);
    spec  = 0;
    m_err = 0;
  endfunction

  function automatic int m_fc();
    return fl_q.size() - spec;
  endfunction

  function automatic bit m_ok(input logic [1:0] rq);
    return m_fc() >= $countones(rq);
  endfunction

  function automatic int m_lane(input logic [1:0] rq, input int lane);
    int k;
    k = 0;
    for (int j = 0; j < lane; j++) if (rq[j]) k++;
    return fl_q[spec + k];
  endfunction

  function automatic void m_step();
    int n, c, room;
    bit okm;
    if (rst) begin
      m_reset();
      return;
    end
    n   = $countones(req);
    okm = m_fc() >= n;
    c   = int'(commit);
    if (c > spec) begin
      m_err = 1;
      c = spec;
    end
    room = DEPTH - fl_q.size();
    for (int j = 0; j < 2; j++) begin
      if (fv[j]) begin
        if (room > 0) begin
          fl_q.push_back(int'(fprn[j]));
          room--;
        end else begin
          m_err = 1;
        end
      end
    end
    repeat (c) void'(fl_q.pop_front());
    spec -= c;
    if (flush) spec = 0;
    else if (okm && n > 0) spec += n;
  endfunction

  task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] v,
                       input int p1, input int p0, input int c, input logic fl);
    @(negedge clk);
    rst     = r;
    req     = rq;
    fv      = v;
    fprn[1] = prn_t'(p1);
    fprn[0] = prn_t'(p0);
    commit  = 2'(c);
    flush   = fl;
    #1;
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
  endtask

  task automatic do_reset();
    drive(1'b1, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    tick();
    drive(1'b1, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 2'b11, 2'b00, 0, 0, 0, 1'b0);
    n_checks++; if (fc !== 16) begin n_fail++; $display("FAIL reset_free_count: got %0d want 16", fc); end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ok: got %0b want 1", ok); end
    n_checks++; if (prn[0] !== 32) begin n_fail++; $display("FAIL reset_prn0: got %0d want 32", prn[0]); end
    n_checks++; if (prn[1] !== 33) begin n_fail++; $display("FAIL reset_prn1: got %0d want 33", prn[1]); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL reset_empty: got %0b want 0", empty); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err); end
    tick();
  endtask

  task automatic test_alloc();
    drive(1'b0, 2'b11, 2'b00, 0, 0, 0, 1'b0);
    n_checks++; if (prn[0] !== 34 || prn[1] !== 35) begin n_fail++; $display("FAIL alloc2_prn: got {%0d,%0d} want {35,34}", prn[1], prn[0]); end
    n_checks++; if (fc !== 14) begin n_fail++; $display("FAIL alloc2_fc: got %0d want 14", fc); end
    tick();
    drive(1'b0, 2'b11, 2'b00, 0, 0, 0, 1'b0);
    n_checks++; if (prn[0] !== 36 || prn[1] !== 37) begin n_fail++; $display("FAIL alloc3_prn: got {%0d,%0d} want {37,36}", prn[1], prn[0]); end
    n_checks++; if (fc !== 12) begin n_fail++; $display("FAIL alloc3_fc: got %0d want 12", fc); end
    tick();
    drive(1'b0, 2'b10, 2'b00, 0, 0, 0, 1'b0);
    n_checks++; if (prn[1] !== 38) begin n_fail++; $display("FAIL lane1_only_prn: got %0d want 38", prn[1]); end
    tick();
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'b11, 2'b00, 0, 0, 0, 1'b0);
      tick();
    end
    drive(1'b0, 2'b11, 2'b00, 0, 0, 0, 1'b0);
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL stall_ok: got %0b want 0", ok); end
    n_checks++; if (fc !== 1) begin n_fail++; $display("FAIL stall_fc: got %0d want 1", fc); end
    tick();
    drive(1'b0, 2'b01, 2'b00, 0, 0, 0, 1'b0);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL last_ok: got %0b want 1", ok); end
    n_checks++; if (fc !== 1) begin n_fail++; $display("FAIL stall_hold_fc: got %0d want 1", fc); end
    n_checks++; if (prn[0] !== 47) begin n_fail++; $display("FAIL last_prn: got %0d want 47", prn[0]); end
    tick();
    drive(1'b0, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drained_empty: got %0b want 1", empty); end
    n_checks++; if (fc !== 0) begin n_fail++; $display("FAIL drained_fc: got %0d want 0", fc); end
    tick();
  endtask

  task automatic test_free_visibility();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 2'b00, 2'b00, 0, 0, 2, 1'b0);
      tick();
    end
    drive(1'b0, 2'b01, 2'b11, 7, 5, 0, 1'b0);
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL free_bypass_ok: got %0b want 0", ok); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL free_bypass_empty: got %0b want 1", empty); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL commit_err: got %0b want 0", err); end
    tick();
    drive(1'b0, 2'b11, 2'b00, 0, 0, 0, 1'b0);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL freed_ok: got %0b want 1", ok); end
    n_checks++; if (prn[0] !== 5 || prn[1] !== 7) begin n_fail++; $display("FAIL freed_prn: got {%0d,%0d} want {7,5}", prn[1], prn[0]); end
    n_checks++; if (fc !== 2) begin n_fail++; $display("FAIL freed_fc: got %0d want 2", fc); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b0, 2'b11, 2'b00, 0, 0, 0, 1'b0);
    tick();
    drive(1'b0, 2'b01, 2'b00, 0, 0, 0, 1'b0);
    tick();
    drive(1'b0, 2'b11, 2'b00, 0, 0, 1, 1'b1);
    n_checks++; if (fc !== 13) begin n_fail++; $display("FAIL preflush_fc: got %0d want 13", fc); end
    tick();
    drive(1'b0, 2'b01, 2'b00, 0, 0, 0, 1'b0);
    n_checks++; if (prn[0] !== 33) begin n_fail++; $display("FAIL flush_prn0: got %0d want 33", prn[0]); end
    n_checks++; if (fc !== 15) begin n_fail++; $display("FAIL flush_fc: got %0d want 15", fc); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL flush_err: got %0b want 0", err); end
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    drive(1'b0, 2'b00, 2'b01, 0, 9, 0, 1'b0);
    tick();
    drive(1'b0, 2'b01, 2'b00, 0, 0, 0, 1'b0);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL overflow_err: got %0b want 1", err); end
    n_checks++; if (fc !== 16) begin n_fail++; $display("FAIL overflow_fc: got %0d want 16", fc); end
    n_checks++; if (prn[0] !== 32) begin n_fail++; $display("FAIL overflow_prn0: got %0d want 32", prn[0]); end
    tick();
    drive(1'b0, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %0b want 1", err); end
    tick();
  endtask

  task automatic test_underflow();
    do_reset();
    drive(1'b0, 2'b00, 2'b00, 0, 0, 1, 1'b0);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL underflow_pre_err: got %0b want 0", err); end
    tick();
    drive(1'b0, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL underflow_err: got %0b want 1", err); end
    n_checks++; if (fc !== 16) begin n_fail++; $display("FAIL underflow_fc: got %0d want 16", fc); end
    tick();
  endtask

  task automatic test_reset_priority();
    drive(1'b0, 2'b11, 2'b00, 0, 0, 0, 1'b0);
    tick();
    drive(1'b1, 2'b11, 2'b11, 3, 4, 2, 1'b1);
    tick();
    drive(1'b0, 2'b11, 2'b00, 0, 0, 0, 1'b0);
    n_checks++; if (fc !== 16) begin n_fail++; $display("FAIL rstprio_fc: got %0d want 16", fc); end
    n_checks++; if (prn[0] !== 32 || prn[1] !== 33) begin n_fail++; $display("FAIL rstprio_prn: got {%0d,%0d} want {33,32}", prn[1], prn[0]); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstprio_err: got %0b want 0", err); end
    tick();
  endtask

  task automatic test_random_wrap();
    logic [1:0] rq, v;
    int c, room, p0, p1;
    logic fl;
    do_reset();
    for (int cyc = 0; cyc < 80; cyc++) begin
      rq   = 2'($urandom_range(0, 3));
      c    = $urandom_range(0, 2);
      if (c > spec) c = spec;
      room = DEPTH - fl_q.size();
      v    = 2'($urandom_range(0, 3));
      if (room < 2 && v == 2'b11) v = 2'b01;
      if (room < 1) v = 2'b00;
      p0   = $urandom_range(0, 47);
      p1   = $urandom_range(0, 47);
      fl   = ($urandom_range(0, 11) == 0);
      drive(1'b0, rq, v, p1, p0, c, fl);
      n_checks++; if (fc !== m_fc()) begin n_fail++; $display("FAIL rnd_fc cyc %0d: got %0d want %0d", cyc, fc, m_fc()); end
      n_checks++; if (ok !== m_ok(rq)) begin n_fail++; $display("FAIL rnd_ok cyc %0d: got %0b want %0b", cyc, ok, m_ok(rq)); end
      n_checks++; if (empty !== (m_fc() == 0)) begin n_fail++; $display("FAIL rnd_empty cyc %0d: got %0b", cyc, empty); end
      n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err cyc %0d: got %0b want %0b", cyc, err, m_err); end
      if (m_ok(rq)) begin
        for (int i = 0; i < 2; i++) begin
          if (rq[i]) begin
            n_checks++;
            if (prn[i] !== m_lane(rq, i)) begin
              n_fail++;
              $display("FAIL rnd_prn cyc %0d lane %0d: got %0d want %0d", cyc, i, prn[i], m_lane(rq, i));
            end
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    rst    = 1'b1;
    req    = '0;
    fv     = '0;
    fprn   = '0;
    commit = '0;
    flush  = 1'b0;
    m_reset();
    test_reset();
    test_alloc();
    test_drain();
    test_free_visibility();
    test_flush();
    test_overflow();
    test_underflow();
    test_reset_priority();
    test_random_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
